// File: rtl/mem_access_sequencer.sv
// -----------------------------------------------------------------------------
// mem_access_sequencer
//
// Sits between the load/store stage and Memory_block. It takes one load or
// store per valid/ready handshake and drives the memory strobes from
// registers.
//
// Access shapes:
//   - Aligned word: a single word access.
//   - Byte: a single byte access.
//   - Misaligned word: split into four byte accesses at addr+0..addr+3.
//     The address wraps modulo 256. Data is little-endian.
//
// Load results are returned with a one-cycle resp_valid pulse. Byte loads
// are zero- or sign-extended.
//
// Ports
//   clk, reset      single clock; synchronous active-high reset
//   req_valid/ready request handshake; ready only in IDLE and not in reset
//   req_write       1 = store, 0 = load
//   req_byte        1 = byte access, 0 = word access
//   req_signed      byte loads: 1 = sign-extend, 0 = zero-extend
//   req_addr        byte address
//   req_wdata       store data (byte stores use [7:0])
//   resp_valid      one-cycle completion pulse
//   resp_rdata      load result (0 for stores), held until the next response
//   mem_address     Memory_block.address
//   mem_write_data  Memory_block.write_data
//   mem_read        Memory_block.memRead
//   mem_write       Memory_block.memWrite
//   mem_byte_op     Memory_block.byteOperations
//   mem_read_data   Memory_block.read_data (combinational, same cycle)
//   split_count     number of misaligned word accesses, saturating at 255
// -----------------------------------------------------------------------------
module mem_access_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_byte_op,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [7:0]        split_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WORD = 2'd1,
    S_BYTE = 2'd2,
    S_RESP = 2'd3
  } state_e;

  // Selects byte lane idx of a 32-bit word.
  function automatic logic [7:0] byte_lane(input logic [DATA_W-1:0] word,
                                           input logic [1:0]        idx);
    logic [7:0] lane;
    case (idx)
      2'd0:    lane = word[7:0];
      2'd1:    lane = word[15:8];
      2'd2:    lane = word[23:16];
      default: lane = word[31:24];
    endcase
    return lane;
  endfunction

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;

  // Latched request fields. They are frozen for the whole access, so any
  // req_* activity outside IDLE is ignored.
  logic                write_q,  write_d;
  logic                signed_q, signed_d;
  logic                split_q,  split_d;   // misaligned word split mode
  logic [ADDR_W-1:0]   addr_q,   addr_d;
  logic [DATA_W-1:0]   wdata_q,  wdata_d;

  logic [1:0]          cnt_q,    cnt_d;     // byte index k within a split
  logic [23:0]         acc_q,    acc_d;     // bytes 0..2 of a split load

  logic                resp_valid_q,     resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q,     resp_rdata_d;
  logic [ADDR_W-1:0]   mem_address_q,    mem_address_d;
  logic [DATA_W-1:0]   mem_write_data_q, mem_write_data_d;
  logic                mem_read_q,       mem_read_d;
  logic                mem_write_q,      mem_write_d;
  logic                mem_byte_op_q,    mem_byte_op_d;
  logic [7:0]          split_count_q,    split_count_d;

  logic                accept;
  logic                req_misaligned;
  logic [1:0]          cnt_nxt;

  // req_ready is the only output decoded from state rather than registered.
  assign req_ready      = (state_q == S_IDLE) && !reset;
  assign accept         = req_valid && req_ready;
  assign req_misaligned = !req_byte && (req_addr[1:0] != 2'b00);
  assign cnt_nxt        = cnt_q + 2'd1;

  // ---------------------------------------------------------------------------
  // Process 1: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Process 2: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = (req_byte || req_misaligned) ? S_BYTE : S_WORD;
        end
      end
      S_WORD:  state_d = S_RESP;
      S_BYTE: begin
        // A single byte access takes one cycle. A split access takes
        // four cycles, k = 0..3.
        if (!split_q || (cnt_q == 2'd3)) begin
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Process 3: output / datapath logic
  // ---------------------------------------------------------------------------
  // Strobes are computed for the access presented in the next cycle, so the
  // memory sees registered values for the whole access cycle.
  always_comb begin
    write_d          = write_q;
    signed_d         = signed_q;
    split_d          = split_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    cnt_d            = cnt_q;
    acc_d            = acc_q;
    resp_valid_d     = 1'b0;
    resp_rdata_d     = resp_rdata_q;
    mem_address_d    = mem_address_q;
    mem_write_data_d = mem_write_data_q;
    mem_read_d       = 1'b0;
    mem_write_d      = 1'b0;
    mem_byte_op_d    = mem_byte_op_q;
    split_count_d    = split_count_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          write_d       = req_write;
          signed_d      = req_signed;
          split_d       = req_misaligned;
          addr_d        = req_addr;
          wdata_d       = req_wdata;
          cnt_d         = 2'd0;
          acc_d         = '0;
          mem_read_d    = !req_write;
          mem_write_d   = req_write;
          mem_byte_op_d = req_byte || req_misaligned;
          mem_address_d = req_addr;
          // Byte 0 of a split store is in the same lane as a plain byte store.
          if (!req_write) begin
            mem_write_data_d = '0;
          end else if (req_byte || req_misaligned) begin
            mem_write_data_d = {24'h0, req_wdata[7:0]};
          end else begin
            mem_write_data_d = req_wdata;
          end
          if (req_misaligned && (split_count_q != 8'hFF)) begin
            split_count_d = split_count_q + 8'd1;
          end
        end
      end

      S_WORD: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = write_q ? '0 : mem_read_data;
      end

      S_BYTE: begin
        if (split_q && (cnt_q != 2'd3)) begin
          // Keep the load byte just read, then present byte k+1.
          case (cnt_q)
            2'd0:    acc_d[7:0]   = mem_read_data[7:0];
            2'd1:    acc_d[15:8]  = mem_read_data[7:0];
            default: acc_d[23:16] = mem_read_data[7:0];
          endcase
          cnt_d            = cnt_nxt;
          mem_read_d       = !write_q;
          mem_write_d      = write_q;
          mem_byte_op_d    = 1'b1;
          mem_address_d    = addr_q + ADDR_W'(cnt_nxt);   // wraps 0xFF -> 0x00
          mem_write_data_d = write_q ? {24'h0, byte_lane(wdata_q, cnt_nxt)} : '0;
        end else begin
          resp_valid_d = 1'b1;
          if (write_q) begin
            resp_rdata_d = '0;
          end else if (split_q) begin
            // The last byte read is the most significant (little-endian).
            resp_rdata_d = {mem_read_data[7:0], acc_q};
          end else begin
            resp_rdata_d = {{24{signed_q & mem_read_data[7]}}, mem_read_data[7:0]};
          end
        end
      end

      default: ;  // S_RESP: strobes drop, resp_valid_q is high this cycle
    endcase
  end

  // Output and datapath registers. Reset aborts any access in flight, so no
  // response is ever issued for it.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_q          <= 1'b0;
      signed_q         <= 1'b0;
      split_q          <= 1'b0;
      addr_q           <= '0;
      wdata_q          <= '0;
      cnt_q            <= 2'd0;
      acc_q            <= '0;
      resp_valid_q     <= 1'b0;
      resp_rdata_q     <= '0;
      mem_address_q    <= '0;
      mem_write_data_q <= '0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_byte_op_q    <= 1'b0;
      split_count_q    <= 8'h00;
    end else begin
      write_q          <= write_d;
      signed_q         <= signed_d;
      split_q          <= split_d;
      addr_q           <= addr_d;
      wdata_q          <= wdata_d;
      cnt_q            <= cnt_d;
      acc_q            <= acc_d;
      resp_valid_q     <= resp_valid_d;
      resp_rdata_q     <= resp_rdata_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
      mem_read_q       <= mem_read_d;
      mem_write_q      <= mem_write_d;
      mem_byte_op_q    <= mem_byte_op_d;
      split_count_q    <= split_count_d;
    end
  end

  assign resp_valid     = resp_valid_q;
  assign resp_rdata     = resp_rdata_q;
  assign mem_address    = mem_address_q;
  assign mem_write_data = mem_write_data_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_byte_op    = mem_byte_op_q;
  assign split_count    = split_count_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mem_access_sequencer
//
// Self-checking bench for mem_access_sequencer.
//
// - A byte-array memory stands in for Memory_block.
// - A separate reference byte array records the data the requests should
//   have stored.
// - Expected load results are computed from that reference array.
// - Expected strobe timing is derived from the request shape.
// -----------------------------------------------------------------------------
module tb_mem_access_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_byte;
  logic        req_signed;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [7:0]  mem_address;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic        mem_byte_op;
  logic [31:0] mem_read_data;
  logic [7:0]  split_count;

  logic        mem_init;
  logic [7:0]  env_mem [256];   // memory as seen by the DUT
  logic [7:0]  ref_mem [256];   // what the requests should have stored
  int          n_checks = 0;
  int          n_errors = 0;
  int          split_model = 0;

  always #5 clk = ~clk;

  mem_access_sequencer #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_byte       (req_byte),
    .req_signed     (req_signed),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_byte_op    (mem_byte_op),
    .mem_read_data  (mem_read_data),
    .split_count    (split_count)
  );

  // Memory_block stand-in: combinational read, write on the rising edge.
  always_comb begin
    if (mem_byte_op) begin
      mem_read_data = {24'h0, env_mem[mem_address]};
    end else begin
      mem_read_data = {env_mem[8'(mem_address + 8'd3)], env_mem[8'(mem_address + 8'd2)],
                       env_mem[8'(mem_address + 8'd1)], env_mem[mem_address]};
    end
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= 8'h00;
    end else if (mem_write) begin
      if (mem_byte_op) begin
        env_mem[mem_address] <= mem_write_data[7:0];
      end else begin
        for (int i = 0; i < 4; i++) env_mem[8'(mem_address + i)] <= mem_write_data[8*i +: 8];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference model: loads read straight from the reference byte array.
  function automatic logic [31:0] model_load(input logic by, input logic sg, input logic [7:0] ad);
    logic [31:0] w;
    if (by) begin
      w = {24'h0, ref_mem[ad]};
      if (sg && ref_mem[ad][7]) w[31:8] = 24'hFF_FFFF;
    end else begin
      for (int k = 0; k < 4; k++) w[8*k +: 8] = ref_mem[8'(ad + k)];
    end
    return w;
  endfunction

  task automatic model_store(input logic by, input logic [7:0] ad, input logic [31:0] wd);
    if (by) ref_mem[ad] = wd[7:0];
    else for (int k = 0; k < 4; k++) ref_mem[8'(ad + k)] = wd[8*k +: 8];
  endtask

  // Issue one request (called at a negedge) and check every cycle of it.
  task automatic issue(input logic wr, input logic by, input logic sg,
                       input logic [7:0] ad, input logic [31:0] wd, input logic [31:0] exp_rd);
    int          n;
    int          nacc;
    logic        is_b;
    logic [7:0]  a;
    logic [31:0] exp_wd;
    nacc = (!by && ad[1:0] != 2'b00) ? 4 : 1;
    is_b = by || (nacc == 4);
    if (nacc == 4 && split_model < 255) split_model++;
    req_valid = 1'b1; req_write = wr; req_byte = by; req_signed = sg;
    req_addr = ad; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 10) begin @(negedge clk); n++; end
    check("ready_wait", {31'h0, req_ready}, 32'h1);
    @(negedge clk);
    // Scramble the request fields; the DUT must ignore them now.
    req_valid = 1'b0; req_write = 1'($urandom); req_byte = 1'($urandom);
    req_signed = 1'($urandom); req_addr = 8'($urandom); req_wdata = $urandom;
    for (int k = 0; k < nacc; k++) begin
      if (k > 0) @(negedge clk);
      a = (nacc == 4) ? 8'(ad + k) : ad;
      check("strobes", {29'h0, mem_read, mem_write, mem_byte_op}, {29'h0, !wr, wr, is_b});
      check("mem_addr", {24'h0, mem_address}, {24'h0, a});
      if (wr) begin
        exp_wd = (nacc == 4) ? {24'h0, wd[8*k +: 8]} : (by ? {24'h0, wd[7:0]} : wd);
        check("mem_wdata", mem_write_data, exp_wd);
      end
      check("resp_early", {31'h0, resp_valid}, 32'h0);
    end
    @(negedge clk);
    check("resp_valid", {31'h0, resp_valid}, 32'h1);
    check("resp_rdata", resp_rdata, exp_rd);
    check("strobes_resp", {30'h0, mem_read, mem_write}, 32'h0);
    check("split_count", {24'h0, split_count}, 32'(split_model));
    @(negedge clk);
    check("resp_pulse", {31'h0, resp_valid}, 32'h0);
    check("ready_back", {31'h0, req_ready}, 32'h1);
    if (wr) model_store(by, ad, wd);
  endtask

  typedef struct {
    logic        wr;
    logic        by;
    logic        sg;
    logic [7:0]  ad;
    logic [31:0] wd;
    logic [31:0] rd;
    int          sc;
  } vec_t;

  vec_t vecs [13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic        wr, by, sg;
    logic [7:0]  ad;
    logic [31:0] wd, er;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 32'h1000_0002, 32'h0000_0000, 0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 32'h0,         32'h1000_0002, 0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 8'h01, 32'h0000_0077, 32'h0000_0000, 0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h01, 32'h0,         32'h0000_0077, 0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 8'h01, 32'h0,         32'h0000_0077, 0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 8'h01, 32'hFFFF_FF85, 32'h0000_0000, 0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 8'h01, 32'h0,         32'hFFFF_FF85, 0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h01, 32'h0,         32'h0000_0085, 0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 8'h02, 32'hAABB_CCDD, 32'h0000_0000, 1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'h02, 32'h0,         32'hAABB_CCDD, 2};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 8'hFE, 32'h1122_3344, 32'h0000_0000, 3};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 8'hFE, 32'h0,         32'h1122_3344, 4};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 32'h0,         32'hCCDD_1122, 4};

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

    // Reset, with req_valid high to show it is not accepted.
    reset = 1'b1; mem_init = 1'b1; req_valid = 1'b1; req_write = 1'b0;
    req_byte = 1'b0; req_signed = 1'b0; req_addr = 8'h00; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'h0, req_ready}, 32'h0);
    check("rst_strobes", {29'h0, mem_read, mem_write, mem_byte_op}, 32'h0);
    check("rst_resp", {31'h0, resp_valid}, 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_addr", {24'h0, mem_address}, 32'h0);
    check("rst_wdata", mem_write_data, 32'h0);
    check("rst_split", {24'h0, split_count}, 32'h0);
    reset = 1'b0; mem_init = 1'b0; req_valid = 1'b0;
    #1;
    check("rst_ready_after", {31'h0, req_ready}, 32'h1);
    @(negedge clk);
    check("rst_no_accept", {30'h0, mem_read, mem_write}, 32'h0);

    // Directed table.
    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].wr, vecs[i].by, vecs[i].sg, vecs[i].ad, vecs[i].wd, vecs[i].rd);
      check("tbl_split", {24'h0, split_count}, 32'(vecs[i].sc));
    end

    // Randomized accesses against the reference model.
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom); by = 1'($urandom); sg = 1'($urandom);
      ad = 8'($urandom); wd = $urandom;
      er = wr ? 32'h0 : model_load(by, sg, ad);
      issue(wr, by, sg, ad, wd, er);
    end

    // Drive split_count into saturation with misaligned loads.
    for (int i = 0; i < 256; i++) begin
      ad = 8'($urandom);
      if (ad[1:0] == 2'b00) ad[0] = 1'b1;
      issue(1'b0, 1'b0, 1'b0, ad, 32'h0, model_load(1'b0, 1'b0, ad));
    end
    check("split_sat", {24'h0, split_count}, 32'd255);

    // Back-to-back aligned loads with req_valid held high.
    req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_addr = 8'h00;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      check("tp_ready", {31'h0, req_ready}, 32'((i % 3) == 0));
      check("tp_resp", {31'h0, resp_valid}, 32'((i % 3) == 2));
      check("tp_excl", {31'h0, mem_read && mem_write}, 32'h0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);

    // Prepare memory and a nonzero resp_rdata, then reset mid split store.
    issue(1'b1, 1'b0, 1'b0, 8'h40, 32'h0, 32'h0);
    issue(1'b1, 1'b0, 1'b0, 8'h44, 32'h0, 32'h0);
    issue(1'b1, 1'b0, 1'b0, 8'h80, 32'hDEAD_BEEF, 32'h0);
    issue(1'b0, 1'b0, 1'b0, 8'h80, 32'h0, 32'hDEAD_BEEF);
    req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0;
    req_addr = 8'h41; req_wdata = 32'hA1B2_C3D4;
    n = 0;
    while (!req_ready && n < 10) begin @(negedge clk); n++; end
    check("rs_ready_wait", {31'h0, req_ready}, 32'h1);
    @(negedge clk);                       // T+1
    req_valid = 1'b0;
    check("rs_b0_addr", {24'h0, mem_address}, 32'h41);
    @(negedge clk);                       // T+2
    check("rs_b1_addr", {24'h0, mem_address}, 32'h42);
    reset = 1'b1;
    @(negedge clk);                       // T+3, still in reset
    req_valid = 1'b1;
    check("rs_ready", {31'h0, req_ready}, 32'h0);
    check("rs_resp", {31'h0, resp_valid}, 32'h0);
    check("rs_rdata", resp_rdata, 32'h0);
    check("rs_strobes", {29'h0, mem_read, mem_write, mem_byte_op}, 32'h0);
    check("rs_addr", {24'h0, mem_address}, 32'h0);
    check("rs_wdata", mem_write_data, 32'h0);
    check("rs_split", {24'h0, split_count}, 32'h0);
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0;
    #1;
    check("rs_ready_after", {31'h0, req_ready}, 32'h1);
    check("rs_no_resp", {31'h0, resp_valid}, 32'h0);
    @(negedge clk);
    check("rs_no_accept", {30'h0, mem_read, mem_write}, 32'h0);
    check("rs_mem41", {24'h0, env_mem[8'h41]}, 32'hD4);
    check("rs_mem42", {24'h0, env_mem[8'h42]}, 32'hC3);
    check("rs_mem43", {24'h0, env_mem[8'h43]}, 32'h00);
    check("rs_mem44", {24'h0, env_mem[8'h44]}, 32'h00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
